// File: rtl/axi_stream_producer.sv
// -----------------------------------------------------------------------------
// axi_stream_producer
//   Deterministic AXI4-Stream traffic source. A start command (accepted only
//   in IDLE) samples beats-per-packet, packet count and data seed, then emits
//   pkt_count packets of pkt_len+1 beats each. Beat n of the command carries
//   tdata = seed + n. Packets are separated by GAP_CYC idle cycles. abort
//   ends the command after the current packet's last beat.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   start                  command pulse, honoured only in IDLE
//   pkt_len, pkt_count     beats-1 per packet, packets per command
//   seed                   tdata of the first beat
//   abort                  level, ends command at the next packet boundary
//   m_tvalid/m_tready      AXI4-Stream handshake
//   m_tdata/m_tkeep/m_tlast AXI4-Stream payload (tkeep always all ones)
//   busy                   high from accepted start until DONE
//   done                   one-cycle pulse at end of command
//   beats_sent             handshaken beats since last accepted start
// -----------------------------------------------------------------------------
module axi_stream_producer #(
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic [CNT_W-1:0]      pkt_count,
  input  logic [DATA_W-1:0]     seed,
  input  logic                  abort,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [DATA_W/8-1:0]   m_tkeep,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beats_sent
);

  localparam int BC_W  = LEN_W + 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_r;     // beats-1 of every packet in this command
  logic [CNT_W-1:0] pkt_left;  // packets still owed, including the current one
  logic [BC_W-1:0]  beat_cnt;  // beat index within the current packet
  logic [GAP_W-1:0] gap_cnt;   // idle cycles already spent in GAP

  logic            hs;
  logic            last_pkt;
  logic            gap_end;
  logic [BC_W-1:0] beat_cnt_nxt;

  assign hs           = m_tvalid & m_tready;
  assign last_pkt     = (pkt_left == CNT_W'(1));
  assign gap_end      = (int'(gap_cnt) == GAP_CYC - 1);
  assign beat_cnt_nxt = beat_cnt + BC_W'(1);

  assign m_tkeep = '1;

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; each branch reads the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_r      <= '0;
      pkt_left   <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beats_sent <= '0;
    end else begin
      done <= 1'b0;
      if (hs) beats_sent <= beats_sent + 32'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            len_r      <= pkt_len;
            pkt_left   <= pkt_count;
            m_tdata    <= seed;
            beat_cnt   <= '0;
            beats_sent <= '0;
            if (pkt_count != '0) begin
              state    <= S_SEND;
              m_tvalid <= 1'b1;
              m_tlast  <= (pkt_len == '0);
              busy     <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        // tvalid is always high in SEND; nothing moves until tready.
        S_SEND: begin
          if (m_tready) begin
            m_tdata <= m_tdata + DATA_W'(1);
            if (!m_tlast) begin
              beat_cnt <= beat_cnt_nxt;
              m_tlast  <= (beat_cnt_nxt == {1'b0, len_r});
            end else begin
              pkt_left <= pkt_left - CNT_W'(1);
              beat_cnt <= '0;
              if (last_pkt || abort) begin
                state    <= S_DONE;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else if (GAP_CYC == 0) begin
                // Back-to-back: tvalid stays high, next packet starts now.
                m_tlast <= (len_r == '0);
              end else begin
                state    <= S_GAP;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                gap_cnt  <= '0;
              end
            end
          end
        end

        S_GAP: begin
          if (abort) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_end) begin
            state    <= S_SEND;
            m_tvalid <= 1'b1;
            m_tlast  <= (len_r == '0);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
